// File: rtl/tot_hit_buffer_if.sv
// Hit-capture and readout signal bundle for tot_hit_buffer.
// The master side is the encoder/consumer environment; the slave side is the buffer.
interface tot_hit_buffer_if #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             hit_valid;
  logic [2:0]       coarse_phase;
  logic [5:0]       fine_phase;
  logic             error_flag;
  logic             drop_errors;
  logic             out_ready;
  logic             out_valid;
  logic [TAG_W+9:0] out_data;
  logic [CNT_W-1:0] fifo_count;
  logic [7:0]       ovf_cnt;
  logic [7:0]       err_cnt;

  modport master (
    output hit_valid, coarse_phase, fine_phase, error_flag, drop_errors, out_ready,
    input  out_valid, out_data, fifo_count, ovf_cnt, err_cnt
  );

  modport slave (
    input  hit_valid, coarse_phase, fine_phase, error_flag, drop_errors, out_ready,
    output out_valid, out_data, fifo_count, ovf_cnt, err_cnt
  );
endinterface

// File: rtl/tot_hit_buffer.sv
// Captures TOT encoder hits, tags them with a rolling sequence number and buffers
// them in a first-word-fall-through FIFO drained by valid/ready, counting lost hits.
module tot_hit_buffer #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  tot_hit_buffer_if.slave bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WORD_W = TAG_W + 10;
  localparam int ERR_BIT = 9;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  typedef logic [WORD_W-1:0] word_t;

  logic [TAG_W-1:0] r_tag;
  logic             r_cap_v;
  word_t            r_cap_word;
  word_t            r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_ovf_cnt;
  logic [7:0]       r_err_cnt;

  logic w_out_valid;
  logic w_full;
  logic w_pop;
  logic w_drop_err;
  logic w_push;
  logic w_ovf;

  assign w_out_valid = (r_count != '0);
  assign w_full      = (r_count == FULL_COUNT);
  assign w_pop       = w_out_valid && bus.out_ready;

  // drop_errors is looked at when the captured word is written, not when it was captured.
  assign w_drop_err = r_cap_v && bus.drop_errors && r_cap_word[ERR_BIT];
  assign w_push     = r_cap_v && !w_drop_err && (!w_full || w_pop);
  assign w_ovf      = r_cap_v && !w_drop_err && w_full && !w_pop;

  // Stage 1: the tag advances on every strobe, so dropped hits leave a visible gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state is always updated with <= so every register
      // samples the pre-edge value of its neighbours, independent of block order.
      r_tag      <= '0;
      r_cap_v    <= 1'b0;
      r_cap_word <= '0;
    end else begin
      r_cap_v <= bus.hit_valid;
      if (bus.hit_valid) begin
        r_cap_word <= {r_tag, bus.error_flag, bus.coarse_phase, bus.fine_phase};
        r_tag      <= r_tag + 1'b1;
      end
    end
  end

  // NOTE: the storage array has no reset; pointers and count define which words
  // are live, and out_data is masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_cap_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ovf_cnt <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_ovf && (r_ovf_cnt != 8'hFF)) begin
        r_ovf_cnt <= r_ovf_cnt + 8'd1;
      end
      if (w_drop_err && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign bus.out_valid  = w_out_valid;
  assign bus.out_data   = w_out_valid ? r_mem[r_rd_ptr] : '0;
  assign bus.fifo_count = r_count;
  assign bus.ovf_cnt    = r_ovf_cnt;
  assign bus.err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_tot_hit_buffer.sv
// Directed bench for tot_hit_buffer: latency, fill/overflow, full push+pop,
// error filtering, randomized backpressure with a scoreboard, reset and saturation.
module tb_tot_hit_buffer;
  localparam int DEPTH = 8;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  int n_checks = 0;
  int n_bad    = 0;

  tot_hit_buffer_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

  tot_hit_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] mk(input logic [3:0] t, input logic e,
                                     input logic [2:0] c, input logic [5:0] f);
    return {t, e, c, f};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hit(input logic [2:0] c, input logic [5:0] f, input logic e);
    bus.hit_valid    = 1'b1;
    bus.coarse_phase = c;
    bus.fine_phase   = f;
    bus.error_flag   = e;
    tick();
    bus.hit_valid    = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  logic [13:0] q[$];
  logic [13:0] last_word;
  logic [3:0]  mtag;
  logic [2:0]  rc;
  logic [5:0]  rf;
  logic        re;
  int          sent;
  int          outstanding;
  int          cyc;

  initial begin
    bus.hit_valid    = 1'b0;
    bus.coarse_phase = '0;
    bus.fine_phase   = '0;
    bus.error_flag   = 1'b0;
    bus.drop_errors  = 1'b0;
    bus.out_ready    = 1'b0;
    tick();
    tick();
    check("rst_valid", bus.out_valid, 0);
    check("rst_data",  bus.out_data, 0);
    check("rst_count", bus.fifo_count, 0);
    check("rst_ovf",   bus.ovf_cnt, 0);
    check("rst_err",   bus.err_cnt, 0);
    reset = 1'b0;

    // Single hit: latency of two cycles into an empty FIFO
    hit(3'd5, 6'd37, 1'b0);
    check("t1_valid_n1", bus.out_valid, 0);
    tick();
    check("t1_valid_n2", bus.out_valid, 1);
    check("t1_data", bus.out_data, mk(4'd0, 1'b0, 3'd5, 6'd37));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("t1_count", bus.fifo_count, 0);
    check("t1_valid_after", bus.out_valid, 0);

    // Fill with 10 back-to-back hits, two overflow
    do_reset();
    for (int i = 0; i < 10; i++) hit(3'(i), 6'(i + 1), 1'b0);
    tick();
    check("t2_count", bus.fifo_count, 8);
    check("t2_ovf", bus.ovf_cnt, 2);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t2_drain%0d", i), bus.out_data, mk(4'(i), 1'b0, 3'(i), 6'(i + 1)));
      tick();
    end
    bus.out_ready = 1'b0;
    check("t2_empty", bus.fifo_count, 0);
    hit(3'd2, 6'd9, 1'b0);
    tick();
    check("t2_next_tag", bus.out_data, mk(4'd10, 1'b0, 3'd2, 6'd9));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Full FIFO with a simultaneous pop: push accepted, no overflow
    for (int i = 0; i < 8; i++) hit(3'(i), 6'(i), 1'b0);
    tick();
    check("t3_full", bus.fifo_count, 8);
    hit(3'd7, 6'd63, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("t3_count", bus.fifo_count, 8);
    check("t3_ovf", bus.ovf_cnt, 2);
    bus.out_ready = 1'b1;
    last_word = '0;
    for (int i = 0; i < 8; i++) begin
      last_word = bus.out_data;
      tick();
    end
    bus.out_ready = 1'b0;
    check("t3_tail", last_word, mk(4'd3, 1'b0, 3'd7, 6'd63));
    check("t3_empty", bus.fifo_count, 0);

    // Error filter
    bus.drop_errors = 1'b1;
    hit(3'd1, 6'd1, 1'b1);
    tick();
    check("t4_err_cnt", bus.err_cnt, 1);
    check("t4_not_stored", bus.fifo_count, 0);
    bus.drop_errors = 1'b0;
    hit(3'd6, 6'd20, 1'b1);
    tick();
    check("t4_kept_valid", bus.out_valid, 1);
    check("t4_kept_data", bus.out_data, mk(4'd5, 1'b1, 3'd6, 6'd20));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    hit(3'd2, 6'd3, 1'b1);
    bus.drop_errors = 1'b1;
    tick();
    bus.drop_errors = 1'b0;
    tick();
    check("t4_stage2_err", bus.err_cnt, 2);
    check("t4_stage2_count", bus.fifo_count, 0);

    // Randomized backpressure against a scoreboard
    do_reset();
    mtag = '0;
    sent = 0;
    outstanding = 0;
    cyc = 0;
    while ((sent < 200 || q.size() != 0) && cyc < 5000) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      if (sent < 200 && outstanding < DEPTH - 2 && $urandom_range(0, 2) != 0) begin
        rc = 3'($urandom_range(0, 7));
        rf = 6'($urandom_range(0, 63));
        re = 1'($urandom_range(0, 1));
        bus.hit_valid    = 1'b1;
        bus.coarse_phase = rc;
        bus.fine_phase   = rf;
        bus.error_flag   = re;
        q.push_back(mk(mtag, re, rc, rf));
        mtag = mtag + 4'd1;
        sent++;
        outstanding++;
      end else begin
        bus.hit_valid = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) check("t5_extra_word", bus.out_data, 0);
        else check("t5_sb", bus.out_data, q.pop_front());
        outstanding--;
      end
      tick();
      cyc++;
    end
    bus.hit_valid = 1'b0;
    bus.out_ready = 1'b0;
    check("t5_timeout", (cyc < 5000), 1);
    check("t5_ovf", bus.ovf_cnt, 0);
    check("t5_err", bus.err_cnt, 0);

    // Reset mid-stream with a hit in the reset cycle
    for (int i = 0; i < 10; i++) hit(3'(i), 6'(i), 1'b0);
    check("t5_mid_count", bus.fifo_count, 8);
    check("t5_mid_ovf", bus.ovf_cnt, 1);
    bus.hit_valid = 1'b1;
    reset = 1'b1;
    tick();
    check("t5_rst_valid", bus.out_valid, 0);
    check("t5_rst_count", bus.fifo_count, 0);
    check("t5_rst_ovf", bus.ovf_cnt, 0);
    check("t5_rst_err", bus.err_cnt, 0);
    check("t5_rst_data", bus.out_data, 0);
    reset = 1'b0;
    bus.hit_valid = 1'b0;
    tick();
    tick();
    tick();
    check("t5_rst_hit_lost", bus.fifo_count, 0);
    hit(3'd4, 6'd44, 1'b0);
    tick();
    check("t5_tag_restart", bus.out_data, mk(4'd0, 1'b0, 3'd4, 6'd44));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Saturation: 300 overflowing hits
    do_reset();
    for (int i = 0; i < 308; i++) hit(3'(i), 6'(i), 1'b0);
    tick();
    tick();
    check("t6_ovf_sat", bus.ovf_cnt, 255);
    check("t6_count", bus.fifo_count, 8);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
